cel_corner_gen: RTL and testbench

CEL_CORNER_GEN -- requirements
Module: cel_corner_gen

---
 rtl/cel_pkg.sv | 22 ++
 rtl/corner_smac.sv | 23 ++
 rtl/cel_corner_gen.sv | 205 ++++++++++++++++++++
 tb/tb_cel_corner_gen.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cel_pkg.sv
// Shared types and constants for the cel corner generator and its serial MAC slices.
package cel_pkg;

   localparam int WH_W     = 11;
   localparam int COORD_W  = 32;
   localparam int OUT_W    = 16;
   localparam int HD_SHIFT = 4;
   localparam int CNT_W    = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MUL_H = 2'd1,
      ST_MUL_W = 2'd2,
      ST_OUT   = 2'd3
   } cel_state_e;

   // 12.20 -> 16.16, arithmetic shift so negative steps round toward minus infinity
   function automatic logic [COORD_W-1:0] hd_to_16p16(input logic [COORD_W-1:0] v);
      return $signed(v) >>> HD_SHIFT;
   endfunction

endpackage

// File: rtl/corner_smac.sv
// Serial multiply-accumulate slice: unsigned 11-bit multiplier times 32-bit multiplicand, one bit per step, LSB first.
module corner_smac
   import cel_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               step,
   input  logic [CNT_W-1:0]   bit_idx,
   input  logic [WH_W-1:0]    mplier,
   input  logic [COORD_W-1:0] mcand,
   output logic [COORD_W-1:0] acc
);

   always_ff @(posedge clk) begin
      if (reset || start) begin
         acc <= '0;
      end else if (step && mplier[bit_idx]) begin
         acc <= acc + (mcand << bit_idx);
      end
   end

endmodule

// File: rtl/cel_corner_gen.sv
// Cel corner generator: four integer corners from origin, steps and size via serial multiplies.
// Define CORNER_HDD_EN to include the per-row hdd step increment in the far-edge corner.
//
// state    | meaning
// ST_IDLE  | waiting for a job, in_ready high
// ST_MUL_H | 11 steps forming h*vd (and h*hdd)
// ST_MUL_W | 11 steps forming w*hd and w*hdF
// ST_OUT   | first cycle loads corners, then holds until out_ready
module cel_corner_gen
   import cel_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [COORD_W-1:0] xpos,
   input  logic [COORD_W-1:0] ypos,
   input  logic [COORD_W-1:0] hdx,
   input  logic [COORD_W-1:0] hdy,
   input  logic [COORD_W-1:0] vdx,
   input  logic [COORD_W-1:0] vdy,
   input  logic [COORD_W-1:0] hddx,
   input  logic [COORD_W-1:0] hddy,
   input  logic [WH_W-1:0]    width,
   input  logic [WH_W-1:0]    height,
   input  logic               in_packed,
   output logic [OUT_W-1:0]   xpoint0,
   output logic [OUT_W-1:0]   xpoint1,
   output logic [OUT_W-1:0]   xpoint2,
   output logic [OUT_W-1:0]   xpoint3,
   output logic [OUT_W-1:0]   ypoint0,
   output logic [OUT_W-1:0]   ypoint1,
   output logic [OUT_W-1:0]   ypoint2,
   output logic [OUT_W-1:0]   ypoint3,
   output logic               out_packed,
   output logic               out_valid,
   input  logic               out_ready
);

   cel_state_e       state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             accept, h_step, w_step, load_out, hs_done;

   logic [COORD_W-1:0] xpos_r, ypos_r, hdx_r, hdy_r, vdx_r, vdy_r;
   logic [WH_W-1:0]    w_r, h_r;
   logic               packed_r;

   logic [COORD_W-1:0] acc_h_vdx, acc_h_vdy;
   logic [COORD_W-1:0] acc_w_hdx, acc_w_hdy, acc_w_hdfx, acc_w_hdfy;
   logic [COORD_W-1:0] hdfx, hdfy;

   assign in_ready = (state == ST_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      accept     = 1'b0;
      h_step     = 1'b0;
      w_step     = 1'b0;
      load_out   = 1'b0;
      hs_done    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (in_valid) begin
               accept     = 1'b1;
               cnt_next   = '0;
               state_next = ST_MUL_H;
            end
         end
         ST_MUL_H: begin
            h_step = 1'b1;
            if (cnt == CNT_W'(WH_W - 1)) begin
               cnt_next   = '0;
               state_next = ST_MUL_W;
            end else begin
               cnt_next = cnt + 4'd1;
            end
         end
         ST_MUL_W: begin
            w_step = 1'b1;
            if (cnt == CNT_W'(WH_W - 1)) begin
               cnt_next   = '0;
               state_next = ST_OUT;
            end else begin
               cnt_next = cnt + 4'd1;
            end
         end
         ST_OUT: begin
            if (!out_valid) begin
               load_out = 1'b1;
            end else if (out_ready) begin
               hs_done    = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         xpos_r   <= '0;
         ypos_r   <= '0;
         hdx_r    <= '0;
         hdy_r    <= '0;
         vdx_r    <= '0;
         vdy_r    <= '0;
         w_r      <= '0;
         h_r      <= '0;
         packed_r <= 1'b0;
      end else if (accept) begin
         xpos_r   <= xpos;
         ypos_r   <= ypos;
         hdx_r    <= hd_to_16p16(hdx);
         hdy_r    <= hd_to_16p16(hdy);
         vdx_r    <= vdx;
         vdy_r    <= vdy;
         w_r      <= width;
         h_r      <= height;
         packed_r <= in_packed;
      end
   end

   corner_smac u_h_vdx (.clk(clk), .reset(reset), .start(accept), .step(h_step), .bit_idx(cnt),
                        .mplier(h_r), .mcand(vdx_r), .acc(acc_h_vdx));
   corner_smac u_h_vdy (.clk(clk), .reset(reset), .start(accept), .step(h_step), .bit_idx(cnt),
                        .mplier(h_r), .mcand(vdy_r), .acc(acc_h_vdy));

`ifdef CORNER_HDD_EN
   logic [COORD_W-1:0] hddx_r, hddy_r;
   logic [COORD_W-1:0] acc_h_hddx, acc_h_hddy;

   always_ff @(posedge clk) begin
      if (reset) begin
         hddx_r <= '0;
         hddy_r <= '0;
      end else if (accept) begin
         hddx_r <= hd_to_16p16(hddx);
         hddy_r <= hd_to_16p16(hddy);
      end
   end

   corner_smac u_h_hddx (.clk(clk), .reset(reset), .start(accept), .step(h_step), .bit_idx(cnt),
                         .mplier(h_r), .mcand(hddx_r), .acc(acc_h_hddx));
   corner_smac u_h_hddy (.clk(clk), .reset(reset), .start(accept), .step(h_step), .bit_idx(cnt),
                         .mplier(h_r), .mcand(hddy_r), .acc(acc_h_hddy));

   // h*hdd is final once MUL_H ends, which is before the first MUL_W step reads it
   assign hdfx = hdx_r + acc_h_hddx;
   assign hdfy = hdy_r + acc_h_hddy;
`else
   logic hdd_unused;
   assign hdd_unused = ^{hddx, hddy};
   assign hdfx       = hdx_r;
   assign hdfy       = hdy_r;
`endif

   corner_smac u_w_hdx  (.clk(clk), .reset(reset), .start(accept), .step(w_step), .bit_idx(cnt),
                         .mplier(w_r), .mcand(hdx_r), .acc(acc_w_hdx));
   corner_smac u_w_hdy  (.clk(clk), .reset(reset), .start(accept), .step(w_step), .bit_idx(cnt),
                         .mplier(w_r), .mcand(hdy_r), .acc(acc_w_hdy));
   corner_smac u_w_hdfx (.clk(clk), .reset(reset), .start(accept), .step(w_step), .bit_idx(cnt),
                         .mplier(w_r), .mcand(hdfx), .acc(acc_w_hdfx));
   corner_smac u_w_hdfy (.clk(clk), .reset(reset), .start(accept), .step(w_step), .bit_idx(cnt),
                         .mplier(w_r), .mcand(hdfy), .acc(acc_w_hdfy));

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid  <= 1'b0;
         out_packed <= 1'b0;
         xpoint0    <= '0;
         xpoint1    <= '0;
         xpoint2    <= '0;
         xpoint3    <= '0;
         ypoint0    <= '0;
         ypoint1    <= '0;
         ypoint2    <= '0;
         ypoint3    <= '0;
      end else if (load_out) begin
         out_valid  <= 1'b1;
         out_packed <= packed_r;
         xpoint0    <= xpos_r[COORD_W-1:COORD_W-OUT_W];
         ypoint0    <= ypos_r[COORD_W-1:COORD_W-OUT_W];
         xpoint1    <= OUT_W'((xpos_r + acc_w_hdx) >> (COORD_W - OUT_W));
         ypoint1    <= OUT_W'((ypos_r + acc_w_hdy) >> (COORD_W - OUT_W));
         xpoint2    <= OUT_W'((xpos_r + acc_h_vdx + acc_w_hdfx) >> (COORD_W - OUT_W));
         ypoint2    <= OUT_W'((ypos_r + acc_h_vdy + acc_w_hdfy) >> (COORD_W - OUT_W));
         xpoint3    <= OUT_W'((xpos_r + acc_h_vdx) >> (COORD_W - OUT_W));
         ypoint3    <= OUT_W'((ypos_r + acc_h_vdy) >> (COORD_W - OUT_W));
      end else if (hs_done) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cel_corner_gen.sv
// Self-checking bench for cel_corner_gen; honours CORNER_HDD_EN when it is defined for the build.
module tb_cel_corner_gen;

`ifdef CORNER_HDD_EN
   localparam bit HDD_EN = 1'b1;
`else
   localparam bit HDD_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] xpos = '0, ypos = '0, hdx = '0, hdy = '0, vdx = '0, vdy = '0, hddx = '0, hddy = '0;
   logic [10:0] width = '0, height = '0;
   logic        in_packed = 1'b0;
   logic [15:0] xpoint0, xpoint1, xpoint2, xpoint3, ypoint0, ypoint1, ypoint2, ypoint3;
   logic        out_packed, out_valid;
   logic        out_ready = 1'b0;

   int checks = 0;
   int errors = 0;

   cel_corner_gen dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .xpos(xpos), .ypos(ypos), .hdx(hdx), .hdy(hdy), .vdx(vdx), .vdy(vdy),
      .hddx(hddx), .hddy(hddy), .width(width), .height(height), .in_packed(in_packed),
      .xpoint0(xpoint0), .xpoint1(xpoint1), .xpoint2(xpoint2), .xpoint3(xpoint3),
      .ypoint0(ypoint0), .ypoint1(ypoint1), .ypoint2(ypoint2), .ypoint3(ypoint3),
      .out_packed(out_packed), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   // Reference: corners straight from the geometric definition, all mod 2^32
   task automatic model(output logic [63:0] ex, output logic [63:0] ey);
      logic [31:0] hx, hy, ddx, ddy, fx, fy, p1x, p1y, p2x, p2y, p3x, p3y;
      hx  = $signed(hdx) >>> 4;
      hy  = $signed(hdy) >>> 4;
      ddx = $signed(hddx) >>> 4;
      ddy = $signed(hddy) >>> 4;
      if (!HDD_EN) begin
         ddx = 32'd0;
         ddy = 32'd0;
      end
      fx  = hx + 32'(height) * ddx;
      fy  = hy + 32'(height) * ddy;
      p1x = xpos + 32'(width) * hx;
      p1y = ypos + 32'(width) * hy;
      p3x = xpos + 32'(height) * vdx;
      p3y = ypos + 32'(height) * vdy;
      p2x = p3x + 32'(width) * fx;
      p2y = p3y + 32'(width) * fy;
      ex  = {p3x[31:16], p2x[31:16], p1x[31:16], xpos[31:16]};
      ey  = {p3y[31:16], p2y[31:16], p1y[31:16], ypos[31:16]};
   endtask

   task automatic scramble();
      xpos = $urandom; ypos = $urandom; hdx = $urandom; hdy = $urandom;
      vdx = $urandom; vdy = $urandom; hddx = $urandom; hddy = $urandom;
      width = 11'($urandom); height = 11'($urandom); in_packed = 1'($urandom);
   endtask

   // Offers the current inputs, scrambles them after acceptance, returns cycles to out_valid (-1 on timeout)
   task automatic accept_job(output int lat);
      int n;
      n   = 0;
      lat = -1;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      scramble();
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic set_basic();
      xpos = 32'h000A0000; ypos = 32'h00140000; hdx = 32'h00100000; hdy = '0;
      vdx = '0; vdy = 32'h00010000; hddx = '0; hddy = '0;
      width = 11'd8; height = 11'd4; in_packed = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid, out_packed} !== 3'b100) begin
         errors++;
         $display("FAIL reset_flags: ready/valid/packed got %b expected 100", {in_ready, out_valid, out_packed});
      end
      checks++;
      if ({xpoint3, xpoint2, xpoint1, xpoint0, ypoint3, ypoint2, ypoint1, ypoint0} !== 128'd0) begin
         errors++;
         $display("FAIL reset_corners: got x=%h y=%h expected all zero",
                  {xpoint3, xpoint2, xpoint1, xpoint0}, {ypoint3, ypoint2, ypoint1, ypoint0});
      end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int lat;
      set_basic();
      accept_job(lat);
      checks++;
      if (lat !== 23) begin
         errors++;
         $display("FAIL basic_latency: got %0d expected 23", lat);
      end
      checks++;
      if ({xpoint3, xpoint2, xpoint1, xpoint0} !== {16'd10, 16'd18, 16'd18, 16'd10}) begin
         errors++;
         $display("FAIL basic_x: got %h expected 000a00120012000a", {xpoint3, xpoint2, xpoint1, xpoint0});
      end
      checks++;
      if ({ypoint3, ypoint2, ypoint1, ypoint0} !== {16'd24, 16'd24, 16'd20, 16'd20}) begin
         errors++;
         $display("FAIL basic_y: got %h expected 0018001800140014", {ypoint3, ypoint2, ypoint1, ypoint0});
      end
      handshake();
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL basic_release: valid/ready got %b expected 01", {out_valid, in_ready});
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({xpoint3, xpoint2, xpoint1, xpoint0} !== {16'd10, 16'd18, 16'd18, 16'd10}) begin
         errors++;
         $display("FAIL basic_persist: got %h expected 000a00120012000a", {xpoint3, xpoint2, xpoint1, xpoint0});
      end
   endtask

   task automatic test_hdd();
      int lat;
      logic [15:0] exp_x2;
      set_basic();
      hddx   = 32'h00040000;
      exp_x2 = HDD_EN ? 16'd26 : 16'd18;
      accept_job(lat);
      checks++;
      if ({xpoint3, xpoint2, xpoint1, xpoint0} !== {16'd10, exp_x2, 16'd18, 16'd10}) begin
         errors++;
         $display("FAIL hdd_x: got %h expected x2=%0d", {xpoint3, xpoint2, xpoint1, xpoint0}, exp_x2);
      end
      checks++;
      if ({ypoint3, ypoint2, ypoint1, ypoint0} !== {16'd24, 16'd24, 16'd20, 16'd20}) begin
         errors++;
         $display("FAIL hdd_y: got %h expected 0018001800140014", {ypoint3, ypoint2, ypoint1, ypoint0});
      end
      handshake();
   endtask

   task automatic test_negative();
      int lat;
      xpos = 32'hFFFB0000; ypos = '0; hdx = 32'hFFF00000; hdy = '0;
      vdx = '0; vdy = '0; hddx = '0; hddy = '0;
      width = 11'd3; height = 11'd0; in_packed = 1'b0;
      accept_job(lat);
      checks++;
      if ({xpoint1, xpoint3} !== {16'hFFF8, 16'hFFFB}) begin
         errors++;
         $display("FAIL negative_x: x1/x3 got %h/%h expected fff8/fffb", xpoint1, xpoint3);
      end
      handshake();
   endtask

   task automatic test_zero_size();
      int lat;
      logic [15:0] org_x, org_y;
      scramble();
      width = 11'd0; height = 11'd0; in_packed = 1'b1;
      org_x = xpos[31:16];
      org_y = ypos[31:16];
      accept_job(lat);
      checks++;
      if ({xpoint3, xpoint2, xpoint1, xpoint0, ypoint3, ypoint2, ypoint1, ypoint0, out_packed}
          !== {org_x, org_x, org_x, org_x, org_y, org_y, org_y, org_y, 1'b1}) begin
         errors++;
         $display("FAIL zero_size: got x=%h y=%h packed=%b expected x=%h y=%h packed=1",
                  {xpoint3, xpoint2, xpoint1, xpoint0}, {ypoint3, ypoint2, ypoint1, ypoint0}, out_packed,
                  {org_x, org_x, org_x, org_x}, {org_y, org_y, org_y, org_y});
      end
      handshake();
   endtask

   task automatic test_backpressure();
      int lat;
      int seen;
      logic [63:0] ex, ey;
      scramble();
      model(ex, ey);
      accept_job(lat);
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({xpoint3, xpoint2, xpoint1, xpoint0, ypoint3, ypoint2, ypoint1, ypoint0, out_valid, in_ready}
             !== {ex, ey, 2'b10}) begin
            errors++;
            $display("FAIL backpressure_hold[%0d]: got x=%h y=%h v/r=%b expected x=%h y=%h v/r=10", i,
                     {xpoint3, xpoint2, xpoint1, xpoint0}, {ypoint3, ypoint2, ypoint1, ypoint0},
                     {out_valid, in_ready}, ex, ey);
         end
      end
      in_valid = 1'b0;
      handshake();
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      checks++;
      if (seen != 0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL backpressure_no_accept: valid cycles %0d ready %b expected 0 and 1", seen, in_ready);
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      set_basic();
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL reset_mid_flags: valid/ready got %b expected 01", {out_valid, in_ready});
      end
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL reset_mid_discard: out_valid seen %0d cycles expected 0", seen);
      end
      test_basic();
   endtask

   task automatic test_random();
      int lat;
      int d;
      logic [63:0] ex, ey;
      logic exp_p;
      for (int j = 0; j < 20; j++) begin
         scramble();
         if (j % 5 == 0) width = 11'd0;
         if (j % 5 == 1) height = 11'd0;
         if (j % 5 == 2) width = 11'h7FF;
         if (j % 5 == 3) height = 11'h7FF;
         model(ex, ey);
         exp_p = in_packed;
         accept_job(lat);
         d = $urandom_range(0, 3);
         repeat (d) @(posedge clk);
         #1;
         checks++;
         if (lat !== 23 || {xpoint3, xpoint2, xpoint1, xpoint0} !== ex ||
             {ypoint3, ypoint2, ypoint1, ypoint0} !== ey || out_packed !== exp_p) begin
            errors++;
            $display("FAIL random[%0d]: got lat=%0d x=%h y=%h p=%b expected lat=23 x=%h y=%h p=%b", j, lat,
                     {xpoint3, xpoint2, xpoint1, xpoint0}, {ypoint3, ypoint2, ypoint1, ypoint0}, out_packed,
                     ex, ey, exp_p);
         end
         handshake();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hdd();
      test_negative();
      test_zero_size();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
